mag_peak_detect: RTL and testbench
==================================

MAG_PEAK_DETECT -- requirements
Module: mag_peak_detect

Interface
- REQ-001: Parameter WIDTH, default 16, is the magnitude sample width in bits.
- REQ-002: Parameter DEPTH, default 256, is the number of bins per frame; it SHALL be a power of two.
- REQ-003: Parameter DEPTH_LOG, default $clog2(DEPTH), is the bin index width.
- REQ-004: Parameter SNR_SHIFT, default 3, sets the detect ratio to peak >= mean * 2^SNR_SHIFT.
- REQ-005: clk  input  1  sole clock; all state changes on the rising edge.
- REQ-006: reset_n  input  1  asynchronous, active-low reset.
- REQ-007: start  input  1  begins a frame scan when sampled high in IDLE.
- REQ-008: mag_valid  input  1  qualifies mag_in; driven by the magnitude stage's enable delayed one cycle.
- REQ-009: mag_in  input  WIDTH  magnitude sample for the current bin; bins arrive in order 0..DEPTH-1.
- REQ-010: busy  output  1  high while in SCAN.
- REQ-011: done  output  1  one-cycle pulse; results are valid.
- REQ-012: peak_bin  output  DEPTH_LOG  index of the largest magnitude in the last frame.
- REQ-013: peak_mag  output  WIDTH  largest magnitude in the last frame.
- REQ-014: mean_mag  output  WIDTH  frame mean, sum >> DEPTH_LOG, truncated.
- REQ-015: detect  output  1  peak_mag >= (mean_mag << SNR_SHIFT).

Function
- REQ-016: The FSM SHALL have three states: IDLE, SCAN and REPORT.
- REQ-017: In IDLE with start=1, the block SHALL enter SCAN and clear the bin counter, running max, running index and accumulator.
- REQ-018: In SCAN, each cycle with mag_valid=1 SHALL accept one sample as bin = counter, then increment the counter.
- REQ-019: Cycles with mag_valid=0 SHALL hold all state; gaps of any length are legal.
- REQ-020: The running max SHALL update only when mag_in is strictly greater than it, so ties keep the lowest bin index.
- REQ-021: The running max SHALL start at 0, and bin 0 SHALL be recorded when all samples are 0.
- REQ-022: The accumulator SHALL be WIDTH+DEPTH_LOG bits wide and SHALL never overflow.
- REQ-023: On the edge that accepts bin DEPTH-1, the block SHALL do all of the following:
  - load peak_bin and peak_mag with values that include that last sample;
  - load mean_mag with the final sum >> DEPTH_LOG;
  - load detect, evaluated in WIDTH+SNR_SHIFT bits with no truncation;
  - enter REPORT.
- REQ-024: REPORT SHALL last exactly one cycle, during which done=1, and SHALL then return to IDLE.
- REQ-025: The latency from the last valid sample edge to done high SHALL be 0 cycles, i.e. done is high in the cycle immediately after that edge.
- REQ-026: peak_bin, peak_mag, mean_mag and detect SHALL hold their values until the next REPORT load.
- REQ-027: mag_valid SHALL be ignored in IDLE and REPORT.
- REQ-028: start SHALL be ignored in SCAN and REPORT; a new frame requires start in IDLE.
- REQ-029: done and busy SHALL never be high together.

Reset
- REQ-030: On reset_n=0, the state SHALL be IDLE, and the counter, running max, index and accumulator SHALL be 0.
- REQ-031: On reset_n=0, busy, done, peak_bin, peak_mag, mean_mag and detect SHALL all be 0.
- REQ-032: Reset mid-SCAN SHALL abort the frame with no done pulse and no output update.
- REQ-033: After reset_n rises, the block SHALL accept start on the next edge.

Verification
- REQ-034: Ramp frame, mag_in = bin, contiguous valid -> peak_bin=255, peak_mag=255, mean_mag=127, detect=0, single done pulse.
- REQ-035: Spike frame, all bins 10 except bin 37 = 5000 -> peak_bin=37, peak_mag=5000, mean_mag=29, detect=1.
- REQ-036: Tie frame, bins 5 and 200 = 900, all others 0 -> peak_bin=5, peak_mag=900, mean_mag=7, detect=1.
- REQ-037: Spike frame with mag_valid every other cycle -> results identical to REQ-035; done only after the 256th valid sample.
- REQ-038: Saturation frame, all bins 0xFFFF -> peak_bin=0, peak_mag=0xFFFF, mean_mag=0xFFFF, detect=0, no accumulator wrap.
- REQ-039: Reset asserted after bin 100 of a frame -> no done, all outputs 0, busy=0; a following full ramp frame gives the REQ-034 results.

Source files
------------

// File: rtl/mag_peak_detect_if.sv
// Handshake and result bundle between the magnitude stage and mag_peak_detect.
// The master side drives start/samples; the slave (the detector) returns the frame results.
interface mag_peak_detect_if #(
    parameter int WIDTH     = 16,
    parameter int DEPTH_LOG = 8
);
    logic                 start;
    logic                 mag_valid;
    logic [WIDTH-1:0]     mag_in;
    logic                 busy;
    logic                 done;
    logic [DEPTH_LOG-1:0] peak_bin;
    logic [WIDTH-1:0]     peak_mag;
    logic [WIDTH-1:0]     mean_mag;
    logic                 detect;

    modport master (
        output start, mag_valid, mag_in,
        input  busy, done, peak_bin, peak_mag, mean_mag, detect
    );

    modport slave (
        input  start, mag_valid, mag_in,
        output busy, done, peak_bin, peak_mag, mean_mag, detect
    );
endinterface

// File: rtl/mag_peak_detect.sv
// Scans one frame of DEPTH magnitude bins, tracking the peak (lowest index on ties) and the mean,
// and flags a detection when the peak exceeds the mean by 2^SNR_SHIFT.
module mag_peak_detect #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 256,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int SNR_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mag_peak_detect_if.slave      bus
);
    localparam int ACC_W = WIDTH + DEPTH_LOG;
    localparam int DET_W = WIDTH + SNR_SHIFT;
    localparam logic [DEPTH_LOG-1:0] LAST_BIN = DEPTH_LOG'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DEPTH_LOG-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     max_q, max_d;
    logic [DEPTH_LOG-1:0] idx_q, idx_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [DEPTH_LOG-1:0] peakBin_q, peakBin_d;
    logic [WIDTH-1:0]     peakMag_q, peakMag_d;
    logic [WIDTH-1:0]     meanMag_q, meanMag_d;
    logic                 detect_q, detect_d;

    logic                 isNewMax;
    logic [WIDTH-1:0]     maxNext;
    logic [DEPTH_LOG-1:0] idxNext;
    logic [ACC_W-1:0]     accNext;
    logic [WIDTH-1:0]     meanNext;
    logic [DET_W-1:0]     peakWide;
    logic [DET_W-1:0]     threshWide;

    // Candidate values for the current sample, so the final bin is folded into the results
    assign isNewMax   = bus.mag_in > max_q;
    assign maxNext    = isNewMax ? bus.mag_in : max_q;
    assign idxNext    = isNewMax ? cnt_q : idx_q;
    assign accNext    = acc_q + ACC_W'(bus.mag_in);
    assign meanNext   = accNext[ACC_W-1:DEPTH_LOG];
    assign peakWide   = DET_W'(maxNext);
    assign threshWide = DET_W'(meanNext) << SNR_SHIFT;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        peakBin_d = peakBin_q;
        peakMag_d = peakMag_q;
        meanMag_d = meanMag_q;
        detect_d  = detect_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    max_d   = '0;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            SCAN: begin
                if (bus.mag_valid) begin
                    cnt_d = cnt_q + DEPTH_LOG'(1);
                    max_d = maxNext;
                    idx_d = idxNext;
                    acc_d = accNext;
                    if (cnt_q == LAST_BIN) begin
                        peakBin_d = idxNext;
                        peakMag_d = maxNext;
                        meanMag_d = meanNext;
                        detect_d  = peakWide >= threshWide;
                        state_d   = REPORT;
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            peakBin_q <= '0;
            peakMag_q <= '0;
            meanMag_q <= '0;
            detect_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            peakBin_q <= peakBin_d;
            peakMag_q <= peakMag_d;
            meanMag_q <= meanMag_d;
            detect_q  <= detect_d;
        end
    end

    assign bus.busy     = (state_q == SCAN);
    assign bus.done     = (state_q == REPORT);
    assign bus.peak_bin = peakBin_q;
    assign bus.peak_mag = peakMag_q;
    assign bus.mean_mag = meanMag_q;
    assign bus.detect   = detect_q;
endmodule

// File: tb/tb_mag_peak_detect.sv
// Directed frames (ramp, spike, tie, gapped spike, saturation, reset abort) against hand-computed results.
module tb_mag_peak_detect;
    localparam int WIDTH     = 16;
    localparam int DEPTH     = 256;
    localparam int DEPTH_LOG = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   passCount  = 0;
    int   failCount  = 0;
    int   checkCount = 0;

    always #5 clk = ~clk;

    mag_peak_detect_if #(.WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) bus ();

    mag_peak_detect #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DEPTH_LOG), .SNR_SHIFT(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] sampleFor(input int mode, input int b);
        case (mode)
            0:       return 16'(b);
            1:       return (b == 37) ? 16'd5000 : 16'd10;
            2:       return (b == 5 || b == 200) ? 16'd900 : 16'd0;
            default: return 16'hFFFF;
        endcase
    endfunction

    task automatic startFrame(input string tag);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checkOutput({tag, "_busyAfterStart"}, 32'(bus.busy), 32'd1);
    endtask

    // Feeds nBins samples; optional idle gap after each, optional stray start mid-frame
    task automatic applyStimulus(input int mode, input bit gaps, input int nBins, input bit pokeStart);
        for (int b = 0; b < nBins; b++) begin
            bus.mag_valid = 1'b1;
            bus.mag_in    = sampleFor(mode, b);
            bus.start     = pokeStart && (b == 50);
            step();
            bus.start = 1'b0;
            if (b < DEPTH - 1) begin
                checkOutput("doneEarly", 32'(bus.done), 32'd0);
                if (gaps) begin
                    bus.mag_valid = 1'b0;
                    bus.mag_in    = 16'hFFFF;
                    step();
                    checkOutput("doneInGap", 32'(bus.done), 32'd0);
                    checkOutput("busyInGap", 32'(bus.busy), 32'd1);
                end
            end
        end
        bus.mag_valid = 1'b0;
        bus.mag_in    = '0;
    endtask

    task automatic checkFrame(input string tag, input int expBin, input int expMag,
                              input int expMean, input int expDet);
        checkOutput({tag, "_done"},     32'(bus.done),     32'd1);
        checkOutput({tag, "_busyLow"},  32'(bus.busy),     32'd0);
        checkOutput({tag, "_peakBin"},  32'(bus.peak_bin), 32'(expBin));
        checkOutput({tag, "_peakMag"},  32'(bus.peak_mag), 32'(expMag));
        checkOutput({tag, "_meanMag"},  32'(bus.mean_mag), 32'(expMean));
        checkOutput({tag, "_detect"},   32'(bus.detect),   32'(expDet));
        step();
        checkOutput({tag, "_donePulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_idleBusy"},  32'(bus.busy), 32'd0);
        step();
        step();
        checkOutput({tag, "_holdBin"},  32'(bus.peak_bin), 32'(expBin));
        checkOutput({tag, "_holdMag"},  32'(bus.peak_mag), 32'(expMag));
        checkOutput({tag, "_holdMean"}, 32'(bus.mean_mag), 32'(expMean));
        checkOutput({tag, "_holdDet"},  32'(bus.detect),   32'(expDet));
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_busy"},    32'(bus.busy),     32'd0);
        checkOutput({tag, "_done"},    32'(bus.done),     32'd0);
        checkOutput({tag, "_peakBin"}, 32'(bus.peak_bin), 32'd0);
        checkOutput({tag, "_peakMag"}, 32'(bus.peak_mag), 32'd0);
        checkOutput({tag, "_meanMag"}, 32'(bus.mean_mag), 32'd0);
        checkOutput({tag, "_detect"},  32'(bus.detect),   32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.mag_valid = 1'b0;
        bus.mag_in    = '0;
        step();
        step();
        checkCleared("reset");

        // Start is raised with reset release and must be taken on the very next edge
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        startFrame("ramp");
        applyStimulus(0, 1'b0, DEPTH, 1'b1);
        checkFrame("ramp", 255, 255, 127, 0);

        // Samples presented while idle must not leak into the next frame
        bus.mag_valid = 1'b1;
        bus.mag_in    = 16'd60000;
        step();
        step();
        checkOutput("idleValidBusy", 32'(bus.busy), 32'd0);
        startFrame("spike");
        applyStimulus(1, 1'b0, DEPTH, 1'b0);
        checkFrame("spike", 37, 5000, 29, 1);

        startFrame("tie");
        applyStimulus(2, 1'b0, DEPTH, 1'b0);
        checkFrame("tie", 5, 900, 7, 1);

        startFrame("gapSpike");
        applyStimulus(1, 1'b1, DEPTH, 1'b0);
        checkFrame("gapSpike", 37, 5000, 29, 1);

        startFrame("sat");
        applyStimulus(3, 1'b0, DEPTH, 1'b0);
        checkFrame("sat", 0, 16'hFFFF, 16'hFFFF, 0);

        startFrame("abort");
        applyStimulus(0, 1'b0, 101, 1'b0);
        reset_n = 1'b0;
        #1;
        checkCleared("abortReset");
        step();
        step();
        checkOutput("abortNoDone", 32'(bus.done), 32'd0);
        reset_n   = 1'b1;
        startFrame("rampAfterAbort");
        applyStimulus(0, 1'b0, DEPTH, 1'b0);
        checkFrame("rampAfterAbort", 255, 255, 127, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop in case the sequence above never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
